cfar_stream_detector: RTL and testbench



---
 rtl/cfar_stream_detector.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_cfar_stream_detector.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfar_stream_detector.sv
// Streaming CA/SOCA/GOCA CFAR detector with a self-flushing sliding window.
// One decision per accepted sample; sums registered, then compare, then output.
module cfar_stream_detector #(
    parameter int INPUT_WIDTH = 16,
    parameter int INDEX_WIDTH = 10,
    parameter int N_TRAIN     = 8,
    parameter int N_GUARD     = 2,
    parameter int ALPHA_WIDTH = 8,
    parameter int ALPHA_FRAC  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             mode,
    input  logic [ALPHA_WIDTH-1:0] alpha,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [INPUT_WIDTH-1:0] power_in,
    input  logic [INDEX_WIDTH-1:0] index_in,
    input  logic                   eop_in,
    output logic                   out_valid,
    output logic                   out_detect,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic [INPUT_WIDTH-1:0] out_power,
    output logic                   out_eop,
    output logic                   busy
);
    localparam int D    = N_TRAIN + N_GUARD;
    localparam int W    = 2 * D + 1;
    localparam int SW   = INPUT_WIDTH + $clog2(N_TRAIN) + 1;
    localparam int PW   = SW + ALPHA_WIDTH + ALPHA_FRAC + 2;
    localparam int CW   = $clog2(D + 1);
    localparam int LAG0 = D + N_GUARD + 1;

    localparam logic [PW-1:0] K1 = PW'(N_TRAIN) << ALPHA_FRAC;
    localparam logic [PW-1:0] K2 = K1 << 1;

    typedef struct packed {
        logic                   v;
        logic                   e;
        logic [INDEX_WIDTH-1:0] ix;
        logic [INPUT_WIDTH-1:0] p;
    } cell_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t                 state_q;
    logic                   ready_q;
    logic [CW-1:0]          cnt_q;
    logic [1:0]             mode_q;
    logic [ALPHA_WIDTH-1:0] alpha_q;

    cell_t                  win_q [W];
    cell_t                  win_d [W];
    cell_t                  new_cell;
    logic [SW-1:0]          lead_q;
    logic [SW-1:0]          lead_d;
    logic [SW-1:0]          lag_q;
    logic [SW-1:0]          lag_d;
    logic                   dec_q;
    logic                   dec_d;

    logic                   accept;
    logic                   start;
    logic                   shift;

    assign input_ready = ready_q;
    assign accept      = input_valid && ready_q;
    assign start       = accept && (state_q == S_IDLE);
    assign shift       = accept || (state_q == S_FLUSH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            cnt_q   <= '0;
            mode_q  <= '0;
            alpha_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        mode_q  <= mode;
                        alpha_q <= alpha;
                        if (eop_in) begin
                            state_q <= S_FLUSH;
                            ready_q <= 1'b0;
                            cnt_q   <= CW'(D - 1);
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (accept && eop_in) begin
                        state_q <= S_FLUSH;
                        ready_q <= 1'b0;
                        cnt_q   <= CW'(D - 1);
                    end
                end
                S_FLUSH: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // A new frame starts from an empty window so no cell of the old frame leaks in.
    always_comb begin
        new_cell = '0;
        if (accept) begin
            new_cell.v  = 1'b1;
            new_cell.e  = eop_in;
            new_cell.ix = index_in;
            new_cell.p  = power_in;
        end
        for (int i = 0; i < W; i++) begin
            win_d[i] = win_q[i];
        end
        lead_d = lead_q;
        lag_d  = lag_q;
        if (shift) begin
            win_d[0] = new_cell;
            for (int i = 1; i < W; i++) begin
                if (start) begin
                    win_d[i] = '0;
                end else begin
                    win_d[i] = win_q[i-1];
                end
            end
            if (start) begin
                lead_d = SW'(new_cell.p);
                lag_d  = '0;
            end else begin
                lead_d = lead_q + SW'(new_cell.p)
                       - SW'(win_q[N_TRAIN-1].p);
                lag_d  = lag_q + SW'(win_q[LAG0-1].p)
                       - SW'(win_q[W-1].p);
            end
        end
        dec_d = shift && win_d[D].v;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < W; i++) begin
                win_q[i] <= '0;
            end
            lead_q <= '0;
            lag_q  <= '0;
            dec_q  <= 1'b0;
        end else begin
            for (int i = 0; i < W; i++) begin
                win_q[i] <= win_d[i];
            end
            lead_q <= lead_d;
            lag_q  <= lag_d;
            dec_q  <= dec_d;
        end
    end

    logic          lead_ok;
    logic          lag_ok;
    logic          both;
    logic          ca;
    logic [SW-1:0] lo;
    logic [SW-1:0] hi;
    logic [PW-1:0] cut;
    logic [PW-1:0] av;
    logic [PW-1:0] lhs_d;
    logic [PW-1:0] rhs_d;
    logic          en_d;

    // Both sides of the inequality are scaled so no division is needed.
    always_comb begin
        lead_ok = 1'b1;
        lag_ok  = 1'b1;
        for (int i = 0; i < N_TRAIN; i++) begin
            lead_ok &= win_q[i].v;
            lag_ok  &= win_q[W-1-i].v;
        end
        lo    = (lead_q < lag_q) ? lead_q : lag_q;
        hi    = (lead_q < lag_q) ? lag_q : lead_q;
        cut   = PW'(win_q[D].p);
        av    = PW'(alpha_q);
        both  = lead_ok && lag_ok;
        ca    = (mode_q == 2'd0) || (mode_q == 2'd3);
        lhs_d = '0;
        rhs_d = '0;
        en_d  = 1'b1;
        unique case (1'b1)
            both && ca: begin
                lhs_d = cut * K2;
                rhs_d = av * (PW'(lead_q) + PW'(lag_q));
            end
            both && (mode_q == 2'd1): begin
                lhs_d = cut * K1;
                rhs_d = av * PW'(lo);
            end
            both && (mode_q == 2'd2): begin
                lhs_d = cut * K1;
                rhs_d = av * PW'(hi);
            end
            lead_ok && !lag_ok: begin
                lhs_d = cut * K1;
                rhs_d = av * PW'(lead_q);
            end
            !lead_ok && lag_ok: begin
                lhs_d = cut * K1;
                rhs_d = av * PW'(lag_q);
            end
            default: begin
                en_d = 1'b0;
            end
        endcase
    end

    logic                   s1_v_q;
    logic                   s1_en_q;
    logic [PW-1:0]          s1_lhs_q;
    logic [PW-1:0]          s1_rhs_q;
    logic [INDEX_WIDTH-1:0] s1_ix_q;
    logic [INPUT_WIDTH-1:0] s1_p_q;
    logic                   s1_e_q;

    logic                   ov_q;
    logic                   od_q;
    logic [INDEX_WIDTH-1:0] oix_q;
    logic [INPUT_WIDTH-1:0] op_q;
    logic                   oe_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q   <= 1'b0;
            s1_en_q  <= 1'b0;
            s1_lhs_q <= '0;
            s1_rhs_q <= '0;
            s1_ix_q  <= '0;
            s1_p_q   <= '0;
            s1_e_q   <= 1'b0;
            ov_q     <= 1'b0;
            od_q     <= 1'b0;
            oix_q    <= '0;
            op_q     <= '0;
            oe_q     <= 1'b0;
        end else begin
            s1_v_q <= dec_q;
            if (dec_q) begin
                s1_en_q  <= en_d;
                s1_lhs_q <= lhs_d;
                s1_rhs_q <= rhs_d;
                s1_ix_q  <= win_q[D].ix;
                s1_p_q   <= win_q[D].p;
                s1_e_q   <= win_q[D].e;
            end
            ov_q <= s1_v_q;
            if (s1_v_q) begin
                od_q  <= s1_en_q && (s1_lhs_q > s1_rhs_q);
                oix_q <= s1_ix_q;
                op_q  <= s1_p_q;
                oe_q  <= s1_e_q;
            end
        end
    end

    assign out_valid  = ov_q;
    assign out_detect = od_q;
    assign out_index  = oix_q;
    assign out_power  = op_q;
    assign out_eop    = oe_q;
    assign busy       = (state_q != S_IDLE) || dec_q || s1_v_q;

endmodule

// File: tb/tb_cfar_stream_detector.sv
// Directed and randomized frames against an array-based CFAR reference.
// Every decision is matched in order against the reference queue.
module tb_cfar_stream_detector;
    localparam int IW = 16;
    localparam int XW = 10;
    localparam int NT = 8;
    localparam int NG = 2;
    localparam int AW = 8;
    localparam int AF = 4;
    localparam int D  = NT + NG;

    typedef int unsigned q_t[$];
    typedef struct {
        int ix;
        int pw;
        bit det;
        bit eop;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    mode = '0;
    logic [AW-1:0] alpha = '0;
    logic          input_valid = 1'b0;
    logic          input_ready;
    logic [IW-1:0] power_in = '0;
    logic [XW-1:0] index_in = '0;
    logic          eop_in = 1'b0;
    logic          out_valid;
    logic          out_detect;
    logic [XW-1:0] out_index;
    logic [IW-1:0] out_power;
    logic          out_eop;
    logic          busy;

    exp_t exp_q[$];
    bit   det_seen [1024];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   ndec = 0;
    bit   chk_en = 0;
    int   eop_cyc = 0;
    int   first_cyc = 0;

    cfar_stream_detector dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .alpha      (alpha),
        .input_valid(input_valid),
        .input_ready(input_ready),
        .power_in   (power_in),
        .index_in   (index_in),
        .eop_in     (eop_in),
        .out_valid  (out_valid),
        .out_detect (out_detect),
        .out_index  (out_index),
        .out_power  (out_power),
        .out_eop    (out_eop),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint want);
        nvec++;
        assert (got === want) else begin
            nerr++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic tick(output bit acc);
        exp_t e;
        acc = input_valid && input_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (chk_en && out_valid) begin
            nvec++;
            assert (exp_q.size() > 0) else begin
                nerr++;
                $error("FAIL spurious: got idx=%0d want no decision", out_index);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                ndec++;
                det_seen[out_index] = out_detect;
                nvec++;
                assert ({out_index, out_power, out_detect, out_eop} ===
                        {XW'(e.ix), IW'(e.pw), e.det, e.eop}) else begin
                    nerr++;
                    $error("FAIL dec: got idx=%0d pw=%0d det=%0b eop=%0b want idx=%0d pw=%0d det=%0b eop=%0b",
                           out_index, out_power, out_detect, out_eop,
                           e.ix, e.pw, e.det, e.eop);
                end
            end
        end
    endtask

    function automatic void model(input q_t p, input int md, input int al);
        int L;
        L = p.size();
        for (int k = 0; k < L; k++) begin
            longint lead;
            longint lag;
            longint c;
            longint a;
            longint s;
            bit lok;
            bit gok;
            bit det;
            lead = 0;
            lag  = 0;
            c    = p[k];
            a    = al;
            s    = 1 << AF;
            lok  = (k + D <= L - 1);
            gok  = (k - D >= 0);
            for (int j = NG + 1; j <= D; j++) begin
                if (k + j < L) lead += p[k+j];
                if (k - j >= 0) lag += p[k-j];
            end
            if (lok && gok) begin
                if (md == 1)
                    det = c * NT * s > a * ((lead < lag) ? lead : lag);
                else if (md == 2)
                    det = c * NT * s > a * ((lead > lag) ? lead : lag);
                else
                    det = c * 2 * NT * s > a * (lead + lag);
            end else if (lok) begin
                det = c * NT * s > a * lead;
            end else if (gok) begin
                det = c * NT * s > a * lag;
            end else begin
                det = 1'b0;
            end
            exp_q.push_back('{k, int'(p[k]), det, k == L - 1});
        end
    endfunction

    function automatic q_t flat(input int n, input int unsigned v);
        q_t f;
        for (int i = 0; i < n; i++) f.push_back(v);
        return f;
    endfunction

    function automatic int unsigned rpow();
        if ($urandom_range(0, 7) == 0) return $urandom_range(0, 65535);
        return $urandom_range(20, 200);
    endfunction

    task automatic run_frame(input q_t p, input int md, input int al, input bit gaps);
        bit a;
        int tries;
        model(p, md, al);
        mode  = 2'(md);
        alpha = AW'(al);
        for (int i = 0; i < p.size(); i++) begin
            if (gaps) begin
                input_valid = 1'b0;
                tick(a);
            end
            input_valid = 1'b1;
            power_in    = IW'(p[i]);
            index_in    = XW'(i);
            eop_in      = (i == p.size() - 1);
            tries = 0;
            do begin
                tick(a);
                tries++;
            end while (!a && tries < 100);
            chk("accept", a, 1);
            if (i == 0) begin
                first_cyc = cyc;
                mode  = 2'($urandom);
                alpha = AW'($urandom);
            end
        end
        input_valid = 1'b0;
        eop_in      = 1'b0;
        eop_cyc     = cyc;
    endtask

    task automatic drain(input string tag);
        int n;
        bit a;
        n = 0;
        while ((exp_q.size() > 0 || busy) && n < 400) begin
            tick(a);
            n++;
        end
        chk({tag, "_drain"}, exp_q.size(), 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, input_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_detect"}, out_detect, 0);
        chk({tag, "_index"}, out_index, 0);
        chk({tag, "_power"}, out_power, 0);
        chk({tag, "_eop"}, out_eop, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit a;
        q_t f;
        int n;
        int prev_eop;
        int d0;

        reset = 1'b1;
        tick(a);
        tick(a);
        check_idle("reset");
        reset = 1'b0;
        tick(a);
        check_idle("idle");
        chk_en = 1'b1;

        f = flat(64, 100);
        f[30] = 1000;
        run_frame(f, 0, 48, 0);
        n = 0;
        while (!input_ready && n < 50) begin
            tick(a);
            n++;
        end
        chk("flush_len", n, 10);
        drain("ca");
        chk("ca_30", det_seen[30], 1);
        chk("ca_29", det_seen[29], 0);

        for (int m = 0; m < 3; m++) begin
            f = flat(64, 100);
            for (int i = 32; i < 64; i++) f[i] = 1000;
            f[26] = 600;
            run_frame(f, (m == 0) ? 1 : (m == 1) ? 2 : 0, 48, 0);
            drain("clutter");
            chk("clutter_26", det_seen[26], (m == 0) ? 1 : 0);
        end

        f = flat(64, 100);
        f[3] = 1000;
        run_frame(f, 3, 48, 0);
        drain("edge");
        chk("edge_3", det_seen[3], 1);
        for (int i = 0; i < 3; i++) begin
            chk("edge_lo", det_seen[i], 0);
            chk("edge_hi", det_seen[61+i], 0);
        end

        f = flat(64, 100);
        f[30] = 300;
        run_frame(f, 0, 48, 0);
        drain("eq300");
        chk("eq_300", det_seen[30], 0);
        f[30] = 301;
        run_frame(f, 0, 48, 0);
        drain("eq301");
        chk("eq_301", det_seen[30], 1);

        f.delete();
        for (int i = 0; i < 64; i++) f.push_back(rpow());
        f[40] = 3000;
        run_frame(f, 0, 48, 1);
        prev_eop = eop_cyc;
        f.delete();
        for (int i = 0; i < 64; i++) f.push_back(rpow());
        run_frame(f, 2, 48, 0);
        chk("b2b_start", first_cyc - prev_eop, 11);
        drain("b2b");

        for (int r = 0; r < 6; r++) begin
            f.delete();
            n = (r == 0) ? 1 : $urandom_range(2, 40);
            for (int i = 0; i < n; i++) f.push_back(rpow());
            run_frame(f, $urandom_range(0, 3), $urandom_range(0, 255),
                      1'($urandom));
            if (r == 2) begin
                f = flat(1, 5000);
                run_frame(f, 0, 0, 0);
            end
        end
        drain("rand");

        chk_en = 1'b0;
        mode   = 2'd0;
        alpha  = AW'(48);
        for (int i = 0; i < 20; i++) begin
            input_valid = 1'b1;
            power_in    = IW'(rpow());
            index_in    = XW'(i);
            n = 0;
            do begin
                tick(a);
                n++;
            end while (!a && n < 100);
            chk("rst_accept", a, 1);
        end
        power_in = IW'(777);
        index_in = XW'(20);
        reset    = 1'b1;
        tick(a);
        check_idle("rst_mid");
        reset       = 1'b0;
        input_valid = 1'b0;
        exp_q.delete();
        chk_en = 1'b1;
        d0 = ndec;
        f.delete();
        for (int i = 0; i < 64; i++) f.push_back(rpow());
        run_frame(f, 0, 48, 0);
        drain("rst");
        chk("rst_count", ndec - d0, 64);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
